inst_rom_loader: RTL

Byte-stream boot loader that writes program words into the instruction memory the OpenMIPS core fetches from. It is the writer side of the instruction-memory interface.
It holds the CPU in reset while loading, assembles big-endian 32-bit words and writes them at consecutive word addresses from 0. It verifies an XOR checksum, then releases the CPU.
It sits in the SOPC between a byte source (UART receiver or test driver) and the instruction RAM write port.

---
 rtl/inst_rom_loader_if.sv | 24 ++
 rtl/inst_rom_loader.sv | 133 +++++++++++++
 2 files changed

// File: rtl/inst_rom_loader_if.sv
// Byte-stream in / instruction-RAM write port out, seen from the loader.
// Signal suffixes are from the loader's point of view.
interface inst_rom_loader_if #(
  parameter int ADDR_W = 10
);
  logic              byte_valid_i;
  logic [7:0]        byte_i;
  logic              byte_ready_o;
  logic              mem_we_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic [31:0]       mem_data_o;

  // Loader side: consumes bytes, drives the RAM write port.
  modport slave (
    input  byte_valid_i, byte_i,
    output byte_ready_o, mem_we_o, mem_addr_o, mem_data_o
  );

  // Byte source / RAM side.
  modport master (
    output byte_valid_i, byte_i,
    input  byte_ready_o, mem_we_o, mem_addr_o, mem_data_o
  );
endinterface

// File: rtl/inst_rom_loader.sv
// Boot loader: holds the CPU in reset, receives a framed big-endian byte
// stream (length, N data words, XOR checksum), writes the words to the
// instruction RAM from address 0, then releases the CPU if the checksum
// matches.
module inst_rom_loader #(
  parameter int ADDR_W  = 10,
  parameter int TIMEOUT = 1000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start_i,
  inst_rom_loader_if.slave    bus,
  output logic                cpu_hold_o,
  output logic                busy_o,
  output logic                done_o,
  output logic                err_o,
  output logic [1:0]          err_code_o,
  output logic [ADDR_W:0]     word_cnt_o
);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [32:0] MAX_N = 33'd1 << ADDR_W;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_HDR  = 3'd1;
  localparam logic [2:0] S_DATA = 3'd2;
  localparam logic [2:0] S_CHK  = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;
  localparam logic [2:0] S_ERR  = 3'd5;

  logic [2:0]        state_q, state_d;
  logic [1:0]        bidx_q, bidx_d;
  logic [23:0]       shreg_q, shreg_d;
  logic [ADDR_W:0]   len_q, len_d;
  logic [ADDR_W:0]   cnt_q, cnt_d;
  logic [31:0]       csum_q, csum_d;
  logic [TW-1:0]     tmo_q, tmo_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       data_q, data_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic [1:0]        code_q, code_d;
  logic              hold_q, hold_d;

  logic              busy, accept;
  logic [31:0]       word;
  logic [ADDR_W:0]   cnt_inc;
  logic [TW-1:0]     tmo_inc;

  assign busy    = (state_q == S_HDR) || (state_q == S_DATA) || (state_q == S_CHK);
  assign accept  = busy && bus.byte_valid_i;
  // Word completed by the byte on the bus (valid only when bidx_q == 3).
  assign word    = {shreg_q, bus.byte_i};
  assign cnt_inc = cnt_q + (ADDR_W+1)'(1);
  assign tmo_inc = tmo_q + TW'(1);

  // Next-state: byte assembly, frame sequencing, checksum and idle timeout.
  always_comb begin
    state_d = state_q;  bidx_d = bidx_q;  shreg_d = shreg_q;  len_d = len_q;
    cnt_d   = cnt_q;    csum_d = csum_q;  tmo_d   = tmo_q;
    we_d    = 1'b0;     addr_d = addr_q;  data_d  = data_q;
    done_d  = done_q;   err_d  = err_q;   code_d  = code_q;   hold_d = hold_q;
    case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        if (start_i) begin
          state_d = S_HDR;  bidx_d = 2'd0;  tmo_d = '0;  cnt_d = '0;
          done_d  = 1'b0;   err_d  = 1'b0;  code_d = 2'd0;  hold_d = 1'b1;
        end
      end
      S_HDR, S_DATA, S_CHK: begin
        if (accept) begin
          // A byte always beats a timeout landing on the same edge.
          tmo_d   = '0;
          shreg_d = {shreg_q[15:0], bus.byte_i};
          bidx_d  = bidx_q + 2'd1;
          if (bidx_q == 2'd3) begin
            if (state_q == S_HDR) begin
              if (word == 32'd0 || {1'b0, word} > MAX_N) begin
                state_d = S_ERR;  err_d = 1'b1;  code_d = 2'd1;
              end else begin
                state_d = S_DATA;  len_d = word[ADDR_W:0];
                cnt_d   = '0;      csum_d = '0;
              end
            end else if (state_q == S_DATA) begin
              we_d   = 1'b1;
              addr_d = cnt_q[ADDR_W-1:0];
              data_d = word;
              cnt_d  = cnt_inc;
              csum_d = csum_q ^ word;
              if (cnt_inc == len_q) state_d = S_CHK;
            end else if (word == csum_q) begin
              state_d = S_DONE;  done_d = 1'b1;  hold_d = 1'b0;
            end else begin
              state_d = S_ERR;   err_d = 1'b1;   code_d = 2'd2;
            end
          end
        end else if (tmo_inc == TW'(TIMEOUT)) begin
          // Partially assembled word is dropped; nothing is written.
          state_d = S_ERR;  err_d = 1'b1;  code_d = 2'd3;  bidx_d = 2'd0;
        end else begin
          tmo_d = tmo_inc;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State registers; reset abandons any load and keeps the CPU held.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;  bidx_q <= '0;  shreg_q <= '0;  len_q <= '0;
      cnt_q   <= '0;      csum_q <= '0;  tmo_q   <= '0;
      we_q    <= 1'b0;    addr_q <= '0;  data_q  <= '0;
      done_q  <= 1'b0;    err_q  <= 1'b0; code_q <= 2'd0; hold_q <= 1'b1;
    end else begin
      state_q <= state_d;  bidx_q <= bidx_d;  shreg_q <= shreg_d;  len_q <= len_d;
      cnt_q   <= cnt_d;    csum_q <= csum_d;  tmo_q   <= tmo_d;
      we_q    <= we_d;     addr_q <= addr_d;  data_q  <= data_d;
      done_q  <= done_d;   err_q  <= err_d;   code_q  <= code_d;  hold_q <= hold_d;
    end
  end

  assign bus.byte_ready_o = busy;
  assign bus.mem_we_o     = we_q;
  assign bus.mem_addr_o   = addr_q;
  assign bus.mem_data_o   = data_q;
  assign cpu_hold_o       = hold_q;
  assign busy_o           = busy;
  assign done_o           = done_q;
  assign err_o            = err_q;
  assign err_code_o       = code_q;
  assign word_cnt_o       = cnt_q;
endmodule
